// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the fifo_reader drain controller.
package fifo_reader_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned FIFO_DEPTH = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_e;

endpackage

// File: rtl/fifo_reader.sv
// Drain-side FIFO controller: read strobe, one-cycle capture, valid/ready output with burst marker.
// Optional even-parity output enabled by defining FIFO_READER_PARITY_EN.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned BURST   = 4,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               fifoEmpty,
  input  logic [DATA_W-1:0]  fifoData,
  output logic               fifoRead,
  output logic [DATA_W-1:0]  data_Out,
  output logic               valid,
  input  logic               ready,
  output logic               last,
  output logic               busy,
  output logic [COUNT_W-1:0] wordsSent
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic               parity
`endif
);

  localparam int unsigned BEAT_W = 4;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [COUNT_W-1:0]  words_q, words_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
`ifdef FIFO_READER_PARITY_EN
  logic                parity_q, parity_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      words_q  <= '0;
      beat_q   <= '0;
`ifdef FIFO_READER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      words_q  <= words_d;
      beat_q   <= beat_d;
`ifdef FIFO_READER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    words_d  = words_q;
    beat_d   = beat_q;
`ifdef FIFO_READER_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (enable && !fifoEmpty) state_d = ISSUE;
      end
      // A started read always completes, regardless of enable.
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d   = fifoData;
        valid_d  = 1'b1;
        last_d   = (beat_q == BEAT_LAST);
`ifdef FIFO_READER_PARITY_EN
        parity_d = ^fifoData;
`endif
        state_d  = PRESENT;
      end
      PRESENT: begin
        if (valid_q && ready) begin
          words_d = words_q + COUNT_W'(1);
          beat_d  = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
          valid_d = 1'b0;
          state_d = (enable && !fifoEmpty) ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifoRead  = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign data_Out  = data_q;
  assign valid     = valid_q;
  assign last      = last_q;
  assign wordsSent = words_q;
`ifdef FIFO_READER_PARITY_EN
  assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: FIFO model, transaction-level reference model and directed vectors.
module tb_fifo_reader;

  localparam int unsigned BURST = 4;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        fifoEmpty;
  logic [15:0] fifoData;
  logic        fifoRead;
  logic [15:0] data_Out;
  logic        valid;
  logic        ready;
  logic        last;
  logic        busy;
  logic [15:0] wordsSent;
`ifdef FIFO_READER_PARITY_EN
  logic        parity;
`endif

  fifo_reader #(.DATA_W(16), .BURST(BURST), .COUNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .fifoEmpty (fifoEmpty),
    .fifoData  (fifoData),
    .fifoRead  (fifoRead),
    .data_Out  (data_Out),
    .valid     (valid),
    .ready     (ready),
    .last      (last),
    .busy      (busy),
    .wordsSent (wordsSent)
`ifdef FIFO_READER_PARITY_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] dlv_q[$];
  logic        dlv_last_q[$];
  int          hs_cyc_q[$];
  int          hs_count = 0;
  int          beat_m   = 0;
  int          age      = 0;
  int          cyc      = 0;
  int          rd_count = 0;
  logic        rd_exp   = 1'b0;
  logic        just_rst = 1'b0;
  logic        armed    = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: a word is read only when no word is in flight, becomes valid two
  // edges after its read, and is retired by the first valid&&ready edge.
  task automatic check_cycle();
    logic hs;
    if (armed) begin
      chk("fifoRead", fifoRead, rd_exp);
      if (fifoRead === 1'b1) begin
        chk("one_word_in_flight", exp_q.size(), 0);
        chk("read_nonempty", fifo_q.size() != 0, 1);
        if (fifo_q.size() != 0) exp_q.push_back(fifo_q[0]);
        age = 0;
      end
      chk("busy", busy, exp_q.size() != 0);
      chk("valid", valid, (exp_q.size() != 0) && (age >= 2));
      if (exp_q.size() != 0 && age >= 2) begin
        chk("data_Out", data_Out, exp_q[0]);
        chk("last", last, beat_m == BURST - 1);
`ifdef FIFO_READER_PARITY_EN
        chk("parity", parity, ^exp_q[0]);
`endif
      end
      if (just_rst) begin
        chk("rst_data_Out", data_Out, 0);
        chk("rst_last", last, 0);
`ifdef FIFO_READER_PARITY_EN
        chk("rst_parity", parity, 0);
`endif
      end
      chk("wordsSent", wordsSent, hs_count[15:0]);
    end
    if (reset === 1'b1) begin
      exp_q.delete();
      hs_count = 0;
      beat_m   = 0;
      rd_exp   = 1'b0;
      just_rst = 1'b1;
    end else begin
      just_rst = 1'b0;
      hs = (valid === 1'b1) && (ready === 1'b1);
      rd_exp = ((exp_q.size() == 0) || hs) && enable && !fifoEmpty;
      if (hs && exp_q.size() != 0) begin
        dlv_q.push_back(exp_q[0]);
        dlv_last_q.push_back(last);
        hs_cyc_q.push_back(cyc);
        void'(exp_q.pop_front());
        hs_count++;
        beat_m = (beat_m == BURST - 1) ? 0 : beat_m + 1;
      end
      age++;
    end
  endtask

  task automatic tick();
    logic rd;
    @(negedge clock);
    check_cycle();
    rd = fifoRead;
    if (rd === 1'b1) rd_count++;
    @(posedge clock);
    #1;
    cyc++;
    if (reset) fifo_q.delete();
    else if (rd === 1'b1 && fifo_q.size() > 0) fifoData = fifo_q.pop_front();
    fifoEmpty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [15:0] w);
    if (fifo_q.size() < 10) fifo_q.push_back(w);
    fifoEmpty = (fifo_q.size() == 0);
  endtask

  task automatic clear_logs();
    dlv_q.delete();
    dlv_last_q.delete();
    hs_cyc_q.delete();
    rd_count = 0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, valid, 1);
  endtask

  initial begin
    int r0;
    int n;
    clock = 1'b0; reset = 1'b1; enable = 1'b0; ready = 1'b0;
    fifoData = '0; fifoEmpty = 1'b1;
    tick();
    armed = 1'b1;
    tick();
    chk("reset_valid", valid, 0);
    chk("reset_data", data_Out, 0);
    chk("reset_words", wordsSent, 0);
    chk("reset_busy", busy, 0);
    chk("reset_read", fifoRead, 0);
    chk("reset_last", last, 0);
    reset = 1'b0;

    // three words, ready held high
    clear_logs();
    push(16'h1111); push(16'h2222); push(16'h3333);
    enable = 1'b1; ready = 1'b1;
    repeat (14) tick();
    chk("t1_words", wordsSent, 3);
    chk("t1_reads", 32'(rd_count), 3);
    chk("t1_cnt", dlv_q.size(), 3);
    if (dlv_q.size() == 3) begin
      chk("t1_w0", dlv_q[0], 16'h1111);
      chk("t1_w1", dlv_q[1], 16'h2222);
      chk("t1_w2", dlv_q[2], 16'h3333);
      chk("t1_gap01", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 3);
      chk("t1_gap12", 32'(hs_cyc_q[2] - hs_cyc_q[1]), 3);
    end

    // burst marker over 9 words after a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    clear_logs();
    for (int i = 1; i <= 9; i++) push(16'(i));
    repeat (32) tick();
    chk("t3_cnt", dlv_q.size(), 9);
    for (int i = 0; i < 9 && i < dlv_q.size(); i++) begin
      chk("t3_word", dlv_q[i], 16'(i + 1));
      chk("t3_last", dlv_last_q[i], (i == 3) || (i == 7));
    end

    // back-pressure
    ready = 1'b0;
    clear_logs();
    push(16'hABCD);
    wait_valid("t2_valid");
    r0 = rd_count;
    repeat (5) begin
      tick();
      chk("t2_hold_data", data_Out, 16'hABCD);
      chk("t2_hold_valid", valid, 1);
    end
    chk("t2_no_read", 32'(rd_count), 32'(r0));
    chk("t2_words_before", wordsSent, 9);
    ready = 1'b1;
    tick();
    chk("t2_words_after", wordsSent, 10);
    chk("t2_last", dlv_last_q.size() == 1 && dlv_last_q[0] == 1'b0, 1);

    // enable dropped during the read-strobe cycle
    clear_logs();
    push(16'h4444); push(16'h5555);
    n = 0;
    while (fifoRead !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t4_issue", fifoRead, 1);
    enable = 1'b0;
    repeat (10) tick();
    chk("t4_reads", 32'(rd_count), 1);
    chk("t4_cnt", dlv_q.size(), 1);
    if (dlv_q.size() == 1) chk("t4_word", dlv_q[0], 16'h4444);
    chk("t4_nonempty", fifoEmpty, 0);
    chk("t4_idle", busy, 0);
    enable = 1'b1;
    repeat (6) tick();
    chk("t4_cnt2", dlv_q.size(), 2);
    if (dlv_q.size() == 2) chk("t4_word2", dlv_q[1], 16'h5555);

    // parity words
    ready = 1'b0;
    push(16'h0007);
    wait_valid("p7_valid");
    chk("p7_data", data_Out, 16'h0007);
`ifdef FIFO_READER_PARITY_EN
    chk("p7_parity", parity, 1);
`endif
    ready = 1'b1; tick(); ready = 1'b0;
    push(16'h0003);
    wait_valid("p3_valid");
    chk("p3_data", data_Out, 16'h0003);
`ifdef FIFO_READER_PARITY_EN
    chk("p3_parity", parity, 0);
`endif
    ready = 1'b1; tick(); ready = 1'b0;

    // reset while presenting, with ready high in the same cycle
    push(16'h5A5A);
    wait_valid("t5_valid");
    chk("t5_data", data_Out, 16'h5A5A);
    reset = 1'b1; ready = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_valid_clr", valid, 0);
    chk("t5_data_clr", data_Out, 0);
    chk("t5_words_clr", wordsSent, 0);
    chk("t5_idle", busy, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Drain-side controller for the 16-bit, 10-deep FIFO. It watches the FIFO's empty flag, issues single-cycle read strobes, captures the word the FIFO presents one cycle later, and delivers it downstream on a valid/ready stream with a burst-boundary marker. It sits between the FIFO's read port and any consumer (serializer, bus master) that needs back-pressure.

## Interface
- DATA_W, 16: word width, matches FIFO data width
- BURST, 4: words per burst (1..15); `last` marks the final word of each burst
- COUNT_W, 16: width of the delivered-word counter
- clock  input  1  rising-edge clock, shared with the FIFO
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = permitted to start new FIFO reads
- fifoEmpty  input  1  FIFO isEmpty flag
- fifoData  input  DATA_W  FIFO data_Out
- fifoRead  output  1  FIFO read strobe, one cycle per word
- data_Out  output  DATA_W  stream data
- valid  output  1  stream data valid
- ready  input  1  downstream accept
- last  output  1  final word of current burst, qualified by valid
- busy  output  1  state != IDLE
- wordsSent  output  COUNT_W  count of completed handshakes, wraps
- parity  output  1  even parity of data_Out (only with FIFO_READER_PARITY_EN)

## Operation
- Reset values: state IDLE, fifoRead 0, data_Out 0, valid 0, last 0, busy 0, wordsSent 0, beat counter 0, parity 0.
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT.
- IDLE: if enable && !fifoEmpty -> ISSUE; else stay.
- ISSUE: fifoRead = 1 (decoded from state register, no combinational input path). Always -> CAPTURE. Independent of enable; a started read always completes.
- CAPTURE: data_Out <= fifoData; valid <= 1; last <= (beat == BURST-1); parity <= ^fifoData. -> PRESENT.
- PRESENT: hold data_Out/valid/last stable until ready. On valid && ready: wordsSent += 1 (mod 2^COUNT_W); beat <= (beat == BURST-1) ? 0 : beat+1; valid <= 0; next = (enable && !fifoEmpty) ? ISSUE : IDLE.
- Handshake: valid never deasserts without ready; data_Out never changes while valid && !ready.
- Exactly one fifoRead pulse per delivered word; never a read while fifoEmpty was 1 at the decision edge.
- enable low: no new ISSUE; in-flight ISSUE/CAPTURE/PRESENT words complete normally. Beat counter is retained across idle gaps; bursts are not truncated by empty FIFO.
- BURST = 1: last = 1 on every word.

## Timing
- fifoEmpty low sampled at edge E0 (in IDLE) -> fifoRead high in cycle E0..E1 -> FIFO updates fifoData at E1 -> captured at E2 -> valid high from E2.
- Latency empty-deassert to valid: 2 edges. Read-strobe to valid: 1 edge after the FIFO's read edge.
- Max throughput with ready held high: 1 word / 3 cycles (PRESENT -> ISSUE -> CAPTURE -> PRESENT).
- reset mid-operation: state, valid, beat and wordsSent clear on the next edge; a word in ISSUE/CAPTURE/PRESENT is discarded (system resets FIFO pointers together).
- reset and ready high in the same cycle: reset wins, wordsSent not incremented.

## Configuration
- FIFO_READER_PARITY_EN defined: `parity` port exists, registered in CAPTURE alongside data_Out, held with it, reset 0.
- Undefined: `parity` port and its register are absent; all other behaviour identical.

## Structure
- Shared package fifo_reader_pkg: state enum typedef (IDLE, ISSUE, CAPTURE, PRESENT), DATA_W default constant, FIFO_DEPTH = 10 constant.
- Single module; no sub-module is warranted.

## Test plan
- Reset then preload FIFO with 0x1111, 0x2222, 0x3333; enable=1, ready=1 -> three fifoRead pulses, data_Out 0x1111/0x2222/0x3333 in order, wordsSent = 3, one valid per 3 cycles.
- Back-pressure: ready low 5 cycles during PRESENT with 0xABCD -> data_Out stays 0xABCD, valid stays 1, no extra fifoRead; ready high -> wordsSent +1.
- BURST=4, 9 words 0x0001..0x0009 -> last high on 0x0004 and 0x0008 only.
- enable dropped in the ISSUE cycle -> word still delivered, then IDLE with fifoEmpty=0 and no further fifoRead until enable returns.
- reset asserted in PRESENT with 0x5A5A held -> next cycle valid=0, data_Out=0, wordsSent=0, state IDLE.
- Macro defined, word 0x0007 -> parity=1; word 0x0003 -> parity=0; macro undefined -> port absent, build clean.
